// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared types and widths for the SDRAM arbiter
package sdram_arbiter_pkg;
   localparam int ADDRESS_WIDTH = 22;
   localparam int DATA_WIDTH    = 16;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} sdram_command_t;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;
endpackage

// File: rtl/sdram_arbiter_rr_priority_select.sv
// rr_priority_select: round-robin pick of the first requester after the pointer
//   i_req    : per-port request vector
//   i_ptr    : last winner; the search starts at i_ptr+1
//   o_onehot : one-hot winner
//   o_valid  : any request present
module rr_priority_select #(
   parameter int NUM_PORTS = 2,
   parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [PW-1:0]        i_ptr,
   output logic [NUM_PORTS-1:0] o_onehot,
   output logic                 o_valid
);
   logic [PW-1:0] w_idx;
   // walk from the lowest priority up so the highest-priority hit is written last
   always_comb begin
      o_onehot = '0;
      w_idx    = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         w_idx = PW'((int'(i_ptr) + k) % NUM_PORTS);
         if (i_req[w_idx]) begin
            o_onehot        = '0;
            o_onehot[w_idx] = 1'b1;
         end
      end
      o_valid = |i_req;
   end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM controller command port
//   clk, reset_n                   : controller clock, async active-low reset
//   req_command/address/data_write : per-port requests (0 idle, 1 write, 2 read)
//   req_grant                      : one-hot owner for the whole transaction
//   req_write_done/req_read_valid  : beat strobes forwarded to the owner only
//   req_data_read                  : read data broadcast to all ports
//   command/data_address/data_write: to the controller
//   data_write_done/read_valid/read: from the controller
//   timeout_error                  : sticky watchdog abort flag
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int BURST_LENGTH   = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_PORTS-1:0][1:0]             req_command,
   input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] req_address,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_data_write,
   output logic [NUM_PORTS-1:0]                  req_grant,
   output logic [NUM_PORTS-1:0]                  req_write_done,
   output logic [NUM_PORTS-1:0]                  req_read_valid,
   output logic [DATA_WIDTH-1:0]                 req_data_read,
   output logic [1:0]                            command,
   output logic [ADDRESS_WIDTH-1:0]              data_address,
   output logic [DATA_WIDTH-1:0]                 data_write,
   input  logic                                  data_write_done,
   input  logic                                  data_read_valid,
   input  logic [DATA_WIDTH-1:0]                 data_read,
   output logic                                  timeout_error
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BW = $clog2(BURST_LENGTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t                 r_state, w_next;
   logic [PW-1:0]          r_ptr, w_win_idx;
   sdram_command_t         r_cmd;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [BW-1:0]          r_beats;
   logic [TW-1:0]          r_wdog;
   logic                   r_timeout;
   logic [NUM_PORTS-1:0]   w_req, w_win, w_grant;
   logic                   w_valid, w_busy, w_beat_w, w_beat_r, w_beat, w_done, w_expire;

   rr_priority_select #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_sel (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_onehot(w_win),
      .o_valid (w_valid)
   );

   always_comb begin
      w_req     = '0;
      w_win_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_req[k] = req_command[k] == WRITE || req_command[k] == READ;
         if (w_win[k]) w_win_idx = PW'(k);
      end
   end

   // only a strobe matching the latched direction counts as a beat
   always_comb begin
      w_busy         = r_state == S_BUSY;
      w_grant        = w_busy ? NUM_PORTS'(1) << r_ptr : '0;
      w_beat_w       = w_busy && r_cmd == WRITE && data_write_done;
      w_beat_r       = w_busy && r_cmd == READ && data_read_valid;
      w_beat         = w_beat_w || w_beat_r;
      w_done         = w_beat && r_beats == BW'(1);
      w_expire       = w_busy && !w_beat && r_wdog == TW'(TIMEOUT_CYCLES - 1);
      w_next         = r_state == S_IDLE ? (w_valid ? S_BUSY : S_IDLE) :
                       r_state == S_BUSY ? ((w_done || w_expire) ? S_GAP : S_BUSY) : S_IDLE;
      req_grant      = w_grant;
      req_write_done = w_beat_w ? w_grant : '0;
      req_read_valid = w_beat_r ? w_grant : '0;
      req_data_read  = data_read;
      command        = w_busy ? r_cmd : IDLE;
      data_address   = w_busy ? r_addr : '0;
      data_write     = w_busy ? req_data_write[r_ptr] : '0;
      timeout_error  = r_timeout;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= PW'(NUM_PORTS - 1);
         r_cmd     <= IDLE;
         r_addr    <= '0;
         r_beats   <= '0;
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_valid) begin
            r_ptr   <= w_win_idx;
            r_cmd   <= sdram_command_t'(req_command[w_win_idx]);
            r_addr  <= req_address[w_win_idx];
            r_beats <= BW'(BURST_LENGTH);
            r_wdog  <= '0;
         end else if (w_busy) begin
            if (w_beat) begin
               r_beats <= r_beats - BW'(1);
               r_wdog  <= '0;
            end else if (r_wdog != TW'(TIMEOUT_CYCLES)) begin
               r_wdog  <= r_wdog + TW'(1);
            end
         end
         if (w_expire) r_timeout <= 1'b1;
      end
   end
endmodule
